// File: rtl/cache_way_array_if.sv
// Bus bundle between the L1 controller (master) and cache_way_array (slave):
// lookup request/response, single-way write port and invalidate-all control.
interface cache_way_array_if #(
  parameter int unsigned WAYS   = 2,
  parameter int unsigned SETS   = 4,
  parameter int unsigned TAG_W  = 28,
  parameter int unsigned DATA_W = 32
);
  localparam int unsigned IDX_W = $clog2(SETS);
  localparam int unsigned WAY_W = $clog2(WAYS);

  logic              lookup_valid;
  logic              lookup_ready;
  logic [IDX_W-1:0]  lookup_index;
  logic [TAG_W-1:0]  lookup_tag;
  logic              resp_valid;
  logic              hit;
  logic [WAY_W-1:0]  hit_way;
  logic [DATA_W-1:0] rdata;
  logic [WAY_W-1:0]  victim_way;
  logic              victim_valid;
  logic              victim_dirty;
  logic [TAG_W-1:0]  victim_tag;
  logic [DATA_W-1:0] victim_data;
  logic              wr_en;
  logic [IDX_W-1:0]  wr_index;
  logic [WAY_W-1:0]  wr_way;
  logic              wr_valid;
  logic              wr_dirty;
  logic [TAG_W-1:0]  wr_tag;
  logic [DATA_W-1:0] wr_data;
  logic              inv_req;
  logic              inv_busy;
  logic              inv_done;

  modport master (
    output lookup_valid, lookup_index, lookup_tag,
    output wr_en, wr_index, wr_way, wr_valid, wr_dirty, wr_tag, wr_data,
    output inv_req,
    input  lookup_ready, resp_valid, hit, hit_way, rdata,
    input  victim_way, victim_valid, victim_dirty, victim_tag, victim_data,
    input  inv_busy, inv_done
  );

  modport slave (
    input  lookup_valid, lookup_index, lookup_tag,
    input  wr_en, wr_index, wr_way, wr_valid, wr_dirty, wr_tag, wr_data,
    input  inv_req,
    output lookup_ready, resp_valid, hit, hit_way, rdata,
    output victim_way, victim_valid, victim_dirty, victim_tag, victim_data,
    output inv_busy, inv_done
  );
endinterface

// File: rtl/cache_way_array.sv
// N-way set-associative tag/data/state array with registered hit detection,
// tree pseudo-LRU victim selection and a sequenced invalidate-all walk.
// Optional feature macro: CACHE_DIRTY_EN (stores dirty bits for write-back use;
// when undefined, no dirty storage exists and victim_dirty is always 0).
module cache_way_array #(
  parameter int unsigned WAYS   = 2,
  parameter int unsigned SETS   = 4,
  parameter int unsigned TAG_W  = 28,
  parameter int unsigned DATA_W = 32
) (
  input logic              clk,
  input logic              rst,
  cache_way_array_if.slave bus
);
  localparam int unsigned IDX_W  = $clog2(SETS);
  localparam int unsigned WAY_W  = $clog2(WAYS);
  localparam int unsigned PLRU_W = WAYS - 1;
  localparam logic [IDX_W-1:0] LAST_SET = IDX_W'(SETS - 1);

  typedef enum logic [1:0] {IDLE, WALK, DONE} inv_state_e;

  inv_state_e       state_q, state_d;
  logic [IDX_W-1:0] cnt_q, cnt_d;

  logic [WAYS-1:0]   valid_q [SETS];
  logic [PLRU_W-1:0] plru_q  [SETS];
  logic [TAG_W-1:0]  tag_q   [SETS][WAYS];
  logic [DATA_W-1:0] data_q  [SETS][WAYS];

  logic              lookup_fire;
  logic              wr_fire;
  logic              hit_c;
  logic [WAY_W-1:0]  hit_way_c;
  logic              any_inv_c;
  logic [WAY_W-1:0]  inv_way_c;
  logic [WAY_W-1:0]  victim_way_c;
  logic              victim_dirty_c;

  // Walk the PLRU tree from the root: a 0 bit means the left subtree is older.
  function automatic logic [WAY_W-1:0] plru_victim(input logic [PLRU_W-1:0] bits);
    logic [WAYS-1:0]  t;
    logic [WAY_W-1:0] node;
    logic [WAY_W-1:0] way;
    logic             dir;
    t    = {1'b0, bits};
    node = '0;
    way  = '0;
    for (int l = 0; l < int'(WAY_W); l++) begin
      dir  = t[node];
      way  = WAY_W'({way, dir});
      node = WAY_W'({node, 1'b0}) + WAY_W'(1) + WAY_W'(dir);
    end
    return way;
  endfunction

  // Point every node on the touched way's path toward the opposite subtree.
  function automatic logic [PLRU_W-1:0] plru_touch(input logic [PLRU_W-1:0] bits,
                                                   input logic [WAY_W-1:0]  way);
    logic [WAYS-1:0]  t;
    logic [WAY_W-1:0] node;
    logic [WAY_W-1:0] w;
    logic             dir;
    t    = {1'b0, bits};
    node = '0;
    w    = way;
    for (int l = 0; l < int'(WAY_W); l++) begin
      dir     = w[WAY_W-1];
      w       = WAY_W'({w, 1'b0});
      t[node] = ~dir;
      node    = WAY_W'({node, 1'b0}) + WAY_W'(1) + WAY_W'(dir);
    end
    return t[PLRU_W-1:0];
  endfunction

  assign lookup_fire = bus.lookup_valid && (state_q == IDLE);
  assign wr_fire     = bus.wr_en && (state_q == IDLE);

  // Tag compare and victim choice on the set being looked up (pre-write view).
  always_comb begin
    hit_c     = 1'b0;
    hit_way_c = '0;
    any_inv_c = 1'b0;
    inv_way_c = '0;
    for (int w = int'(WAYS) - 1; w >= 0; w--) begin
      if (valid_q[bus.lookup_index][w] && (tag_q[bus.lookup_index][w] == bus.lookup_tag)) begin
        hit_c     = 1'b1;
        hit_way_c = WAY_W'(w);
      end
      if (!valid_q[bus.lookup_index][w]) begin
        any_inv_c = 1'b1;
        inv_way_c = WAY_W'(w);
      end
    end
    victim_way_c = any_inv_c ? inv_way_c : plru_victim(plru_q[bus.lookup_index]);
  end

`ifdef CACHE_DIRTY_EN
  logic [WAYS-1:0] dirty_q [SETS];

  // Dirty bits follow the valid bits' clear/write rules.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int s = 0; s < int'(SETS); s++) dirty_q[s] <= '0;
    end else if (state_q == WALK) begin
      dirty_q[cnt_q] <= '0;
    end else if (wr_fire) begin
      dirty_q[bus.wr_index][bus.wr_way] <= bus.wr_dirty;
    end
  end

  assign victim_dirty_c = dirty_q[bus.lookup_index][victim_way_c];
`else
  logic unused_wr_dirty;
  assign unused_wr_dirty = bus.wr_dirty;
  assign victim_dirty_c  = 1'b0;
`endif

  // Invalidate FSM next-state: IDLE -> WALK (SETS cycles) -> DONE -> IDLE.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (bus.inv_req) begin
          state_d = WALK;
          cnt_d   = '0;
        end
      end
      WALK: begin
        cnt_d = cnt_q + IDX_W'(1);
        if (cnt_q == LAST_SET) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM state, set counter and the status outputs decoded from the next state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q          <= IDLE;
      cnt_q            <= '0;
      bus.inv_busy     <= 1'b0;
      bus.inv_done     <= 1'b0;
      bus.lookup_ready <= 1'b1;
    end else begin
      state_q          <= state_d;
      cnt_q            <= cnt_d;
      bus.inv_busy     <= (state_d != IDLE);
      bus.inv_done     <= (state_d == DONE);
      bus.lookup_ready <= (state_d == IDLE);
    end
  end

  // Valid and PLRU state; a write touch in the same set overrides the hit touch.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int s = 0; s < int'(SETS); s++) begin
        valid_q[s] <= '0;
        plru_q[s]  <= '0;
      end
    end else if (state_q == WALK) begin
      valid_q[cnt_q] <= '0;
      plru_q[cnt_q]  <= '0;
    end else begin
      if (lookup_fire && hit_c && !(wr_fire && (bus.wr_index == bus.lookup_index))) begin
        plru_q[bus.lookup_index] <= plru_touch(plru_q[bus.lookup_index], hit_way_c);
      end
      if (wr_fire) begin
        valid_q[bus.wr_index][bus.wr_way] <= bus.wr_valid;
        plru_q[bus.wr_index]              <= plru_touch(plru_q[bus.wr_index], bus.wr_way);
      end
    end
  end

  // Tag and data payload storage; not reset, qualified by the valid bits.
  always_ff @(posedge clk) begin
    if (wr_fire) begin
      tag_q[bus.wr_index][bus.wr_way]  <= bus.wr_tag;
      data_q[bus.wr_index][bus.wr_way] <= bus.wr_data;
    end
  end

  // Registered lookup response; results hold until the next accepted lookup.
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.resp_valid   <= 1'b0;
      bus.hit          <= 1'b0;
      bus.hit_way      <= '0;
      bus.rdata        <= '0;
      bus.victim_way   <= '0;
      bus.victim_valid <= 1'b0;
      bus.victim_dirty <= 1'b0;
      bus.victim_tag   <= '0;
      bus.victim_data  <= '0;
    end else begin
      bus.resp_valid <= lookup_fire;
      if (lookup_fire) begin
        bus.hit          <= hit_c;
        bus.hit_way      <= hit_way_c;
        bus.rdata        <= hit_c ? data_q[bus.lookup_index][hit_way_c] : '0;
        bus.victim_way   <= victim_way_c;
        bus.victim_valid <= valid_q[bus.lookup_index][victim_way_c];
        bus.victim_dirty <= victim_dirty_c;
        bus.victim_tag   <= tag_q[bus.lookup_index][victim_way_c];
        bus.victim_data  <= data_q[bus.lookup_index][victim_way_c];
      end
    end
  end

endmodule

// File: tb/tb_cache_way_array.sv
// Directed bench for cache_way_array: a 2-way and a 4-way instance, 4 sets each.
module tb_cache_way_array;
  logic clk;
  logic rst;
  int   total;
  int   bad;

  cache_way_array_if #(.WAYS(2), .SETS(4), .TAG_W(28), .DATA_W(32)) b2 ();
  cache_way_array_if #(.WAYS(4), .SETS(4), .TAG_W(28), .DATA_W(32)) b4 ();

  cache_way_array #(.WAYS(2), .SETS(4), .TAG_W(28), .DATA_W(32)) u2 (
    .clk(clk), .rst(rst), .bus(b2));
  cache_way_array #(.WAYS(4), .SETS(4), .TAG_W(28), .DATA_W(32)) u4 (
    .clk(clk), .rst(rst), .bus(b4));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic lk2(input logic [1:0] idx, input logic [27:0] tag);
    @(negedge clk);
    b2.lookup_valid = 1'b1; b2.lookup_index = idx; b2.lookup_tag = tag;
    @(posedge clk); #1;
    b2.lookup_valid = 1'b0;
  endtask

  task automatic wr2(input logic [1:0] idx, input logic way, input logic v, input logic d,
                     input logic [27:0] tag, input logic [31:0] data);
    @(negedge clk);
    b2.wr_en = 1'b1; b2.wr_index = idx; b2.wr_way = way; b2.wr_valid = v;
    b2.wr_dirty = d; b2.wr_tag = tag; b2.wr_data = data;
    @(posedge clk); #1;
    b2.wr_en = 1'b0;
  endtask

  task automatic lk4(input logic [1:0] idx, input logic [27:0] tag);
    @(negedge clk);
    b4.lookup_valid = 1'b1; b4.lookup_index = idx; b4.lookup_tag = tag;
    @(posedge clk); #1;
    b4.lookup_valid = 1'b0;
  endtask

  task automatic wr4(input logic [1:0] idx, input logic [1:0] way,
                     input logic [27:0] tag, input logic [31:0] data);
    @(negedge clk);
    b4.wr_en = 1'b1; b4.wr_index = idx; b4.wr_way = way; b4.wr_valid = 1'b1;
    b4.wr_dirty = 1'b0; b4.wr_tag = tag; b4.wr_data = data;
    @(posedge clk); #1;
    b4.wr_en = 1'b0;
  endtask

  task automatic test_reset();
    total++; if (b2.resp_valid !== 1'b0) begin bad++; $display("FAIL rst_resp_valid: got %0b want 0", b2.resp_valid); end
    total++; if (b2.lookup_ready !== 1'b1) begin bad++; $display("FAIL rst_lookup_ready: got %0b want 1", b2.lookup_ready); end
    total++; if (b2.inv_busy !== 1'b0 || b2.inv_done !== 1'b0) begin bad++; $display("FAIL rst_inv: busy=%0b done=%0b want 0 0", b2.inv_busy, b2.inv_done); end
    total++; if (b2.victim_tag !== 28'h0 || b2.rdata !== 32'h0) begin bad++; $display("FAIL rst_data: vtag=%0h rdata=%0h want 0 0", b2.victim_tag, b2.rdata); end
    lk2(2'd2, 28'h5);
    total++; if (b2.resp_valid !== 1'b1) begin bad++; $display("FAIL rst_lk_resp: got %0b want 1", b2.resp_valid); end
    total++; if (b2.hit !== 1'b0) begin bad++; $display("FAIL rst_lk_hit: got %0b want 0", b2.hit); end
    total++; if (b2.victim_way !== 1'b0 || b2.victim_valid !== 1'b0) begin bad++; $display("FAIL rst_lk_victim: way=%0d valid=%0b want 0 0", b2.victim_way, b2.victim_valid); end
  endtask

  task automatic test_hit_and_lru();
    wr2(2'd1, 1'b0, 1'b1, 1'b0, 28'hA, 32'h1234);
    wr2(2'd1, 1'b1, 1'b1, 1'b0, 28'hB, 32'h5678);
    lk2(2'd1, 28'hA);
    total++; if (b2.hit !== 1'b1 || b2.hit_way !== 1'b0) begin bad++; $display("FAIL hit_a: hit=%0b way=%0d want 1 0", b2.hit, b2.hit_way); end
    total++; if (b2.rdata !== 32'h1234) begin bad++; $display("FAIL hit_a_data: got %0h want 1234", b2.rdata); end
    lk2(2'd1, 28'hC);
    total++; if (b2.hit !== 1'b0 || b2.rdata !== 32'h0) begin bad++; $display("FAIL miss_c: hit=%0b rdata=%0h want 0 0", b2.hit, b2.rdata); end
    total++; if (b2.victim_way !== 1'b1 || b2.victim_valid !== 1'b1) begin bad++; $display("FAIL miss_c_victim: way=%0d valid=%0b want 1 1", b2.victim_way, b2.victim_valid); end
    total++; if (b2.victim_tag !== 28'hB || b2.victim_data !== 32'h5678) begin bad++; $display("FAIL miss_c_vdata: tag=%0h data=%0h want b 5678", b2.victim_tag, b2.victim_data); end
    @(posedge clk); #1;
    total++; if (b2.resp_valid !== 1'b0 || b2.victim_way !== 1'b1) begin bad++; $display("FAIL hold: resp=%0b vway=%0d want 0 1", b2.resp_valid, b2.victim_way); end
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    b2.lookup_valid = 1'b1; b2.lookup_index = 2'd1; b2.lookup_tag = 28'hB;
    @(posedge clk); #1;
    total++; if (b2.resp_valid !== 1'b1 || b2.hit !== 1'b1 || b2.hit_way !== 1'b1 || b2.rdata !== 32'h5678) begin
      bad++; $display("FAIL b2b_first: resp=%0b hit=%0b way=%0d rdata=%0h want 1 1 1 5678", b2.resp_valid, b2.hit, b2.hit_way, b2.rdata); end
    @(negedge clk);
    b2.lookup_tag = 28'hA;
    @(posedge clk); #1;
    b2.lookup_valid = 1'b0;
    total++; if (b2.resp_valid !== 1'b1 || b2.hit !== 1'b1 || b2.hit_way !== 1'b0 || b2.rdata !== 32'h1234) begin
      bad++; $display("FAIL b2b_second: resp=%0b hit=%0b way=%0d rdata=%0h want 1 1 0 1234", b2.resp_valid, b2.hit, b2.hit_way, b2.rdata); end
  endtask

  task automatic test_read_old();
    @(negedge clk);
    b2.wr_en = 1'b1; b2.wr_index = 2'd3; b2.wr_way = 1'b1; b2.wr_valid = 1'b1;
    b2.wr_dirty = 1'b0; b2.wr_tag = 28'h7; b2.wr_data = 32'h77;
    b2.lookup_valid = 1'b1; b2.lookup_index = 2'd3; b2.lookup_tag = 28'h7;
    @(posedge clk); #1;
    b2.wr_en = 1'b0; b2.lookup_valid = 1'b0;
    total++; if (b2.hit !== 1'b0) begin bad++; $display("FAIL read_old: hit=%0b want 0", b2.hit); end
    lk2(2'd3, 28'h7);
    total++; if (b2.hit !== 1'b1 || b2.hit_way !== 1'b1 || b2.rdata !== 32'h77) begin
      bad++; $display("FAIL read_new: hit=%0b way=%0d rdata=%0h want 1 1 77", b2.hit, b2.hit_way, b2.rdata); end
  endtask

  task automatic test_dirty();
    logic exp_d;
`ifdef CACHE_DIRTY_EN
    exp_d = 1'b1;
`else
    exp_d = 1'b0;
`endif
    wr2(2'd0, 1'b0, 1'b1, 1'b1, 28'h11, 32'h1);
    wr2(2'd0, 1'b1, 1'b1, 1'b0, 28'h12, 32'h2);
    lk2(2'd0, 28'h99);
    total++; if (b2.victim_way !== 1'b0 || b2.victim_tag !== 28'h11) begin bad++; $display("FAIL dirty_victim: way=%0d tag=%0h want 0 11", b2.victim_way, b2.victim_tag); end
    total++; if (b2.victim_dirty !== exp_d) begin bad++; $display("FAIL victim_dirty: got %0b want %0b", b2.victim_dirty, exp_d); end
  endtask

  task automatic test_plru4();
    for (int w = 0; w < 4; w++) wr4(2'd0, 2'(w), 28'(32'h20 + w), 32'h100 + w);
    for (int w = 0; w < 4; w++) lk4(2'd0, 28'(32'h20 + w));
    total++; if (b4.hit !== 1'b1 || b4.hit_way !== 2'd3 || b4.rdata !== 32'h103) begin
      bad++; $display("FAIL plru_hit3: hit=%0b way=%0d rdata=%0h want 1 3 103", b4.hit, b4.hit_way, b4.rdata); end
    lk4(2'd0, 28'h55);
    total++; if (b4.hit !== 1'b0 || b4.victim_way !== 2'd0 || b4.victim_tag !== 28'h20) begin
      bad++; $display("FAIL plru_miss1: hit=%0b vway=%0d vtag=%0h want 0 0 20", b4.hit, b4.victim_way, b4.victim_tag); end
    lk4(2'd0, 28'h20);
    lk4(2'd0, 28'h55);
    total++; if (b4.victim_way !== 2'd2 || b4.victim_data !== 32'h102 || b4.victim_valid !== 1'b1) begin
      bad++; $display("FAIL plru_miss2: vway=%0d vdata=%0h vvalid=%0b want 2 102 1", b4.victim_way, b4.victim_data, b4.victim_valid); end
    wr4(2'd1, 2'd0, 28'h40, 32'h40);
    wr4(2'd1, 2'd2, 28'h42, 32'h42);
    lk4(2'd1, 28'h55);
    total++; if (b4.victim_way !== 2'd1 || b4.victim_valid !== 1'b0) begin
      bad++; $display("FAIL invalid_first: vway=%0d vvalid=%0b want 1 0", b4.victim_way, b4.victim_valid); end
  endtask

  task automatic test_invalidate();
    int busy_n, done_n, ready_bad, resp_bad;
    logic [27:0] tags [4];
    tags[0] = 28'h20; tags[1] = 28'h40; tags[2] = 28'h30; tags[3] = 28'h31;
    wr4(2'd2, 2'd0, 28'h30, 32'h30);
    wr4(2'd3, 2'd0, 28'h31, 32'h31);
    @(negedge clk);
    b4.inv_req = 1'b1;
    b4.lookup_valid = 1'b1; b4.lookup_index = 2'd2; b4.lookup_tag = 28'h30;
    @(posedge clk); #1;
    b4.inv_req = 1'b0; b4.lookup_valid = 1'b0;
    total++; if (b4.resp_valid !== 1'b1 || b4.hit !== 1'b1 || b4.hit_way !== 2'd0) begin
      bad++; $display("FAIL lk_with_inv: resp=%0b hit=%0b way=%0d want 1 1 0", b4.resp_valid, b4.hit, b4.hit_way); end
    busy_n = 0; done_n = 0; ready_bad = 0; resp_bad = 0;
    b4.wr_index = 2'd0; b4.wr_way = 2'd1; b4.wr_valid = 1'b1; b4.wr_tag = 28'h77; b4.wr_data = 32'h77;
    b4.lookup_index = 2'd0; b4.lookup_tag = 28'h20;
    for (int c = 0; c < 20; c++) begin
      if (b4.inv_busy) begin busy_n++; if (b4.lookup_ready) ready_bad++; end
      if (b4.inv_done) done_n++;
      if (c > 0 && b4.resp_valid) resp_bad++;
      @(negedge clk);
      b4.wr_en = b4.inv_busy; b4.lookup_valid = b4.inv_busy;
      @(posedge clk); #1;
    end
    b4.wr_en = 1'b0; b4.lookup_valid = 1'b0;
    total++; if (busy_n != 5) begin bad++; $display("FAIL inv_busy_len: got %0d want 5", busy_n); end
    total++; if (done_n != 1) begin bad++; $display("FAIL inv_done_cnt: got %0d want 1", done_n); end
    total++; if (ready_bad != 0) begin bad++; $display("FAIL inv_ready: ready high %0d busy cycles want 0", ready_bad); end
    total++; if (resp_bad != 0) begin bad++; $display("FAIL inv_lk_ignored: got %0d responses want 0", resp_bad); end
    for (int s = 0; s < 4; s++) begin
      lk4(2'(s), tags[s]);
      total++; if (b4.hit !== 1'b0 || b4.victim_valid !== 1'b0) begin
        bad++; $display("FAIL inv_set%0d: hit=%0b vvalid=%0b want 0 0", s, b4.hit, b4.victim_valid); end
    end
    lk4(2'd0, 28'h77);
    total++; if (b4.hit !== 1'b0) begin bad++; $display("FAIL inv_wr_ignored: hit=%0b want 0", b4.hit); end
  endtask

  task automatic test_reset_mid_walk();
    int done_n;
    wr4(2'd0, 2'd0, 28'h20, 32'h20);
    wr4(2'd2, 2'd0, 28'h30, 32'h30);
    @(negedge clk); b4.inv_req = 1'b1;
    @(posedge clk); #1; b4.inv_req = 1'b0;
    done_n = 0;
    @(posedge clk); #1;
    if (b4.inv_done) done_n++;
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    total++; if (b4.inv_busy !== 1'b0 || b4.lookup_ready !== 1'b1) begin
      bad++; $display("FAIL rst_walk_state: busy=%0b ready=%0b want 0 1", b4.inv_busy, b4.lookup_ready); end
    @(negedge clk); rst = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      if (b4.inv_done) done_n++;
    end
    total++; if (done_n != 0) begin bad++; $display("FAIL rst_walk_done: got %0d pulses want 0", done_n); end
    lk4(2'd2, 28'h30);
    total++; if (b4.hit !== 1'b0 || b4.victim_valid !== 1'b0) begin bad++; $display("FAIL rst_walk_set2: hit=%0b vvalid=%0b want 0 0", b4.hit, b4.victim_valid); end
    lk4(2'd0, 28'h20);
    total++; if (b4.hit !== 1'b0) begin bad++; $display("FAIL rst_walk_set0: hit=%0b want 0", b4.hit); end
  endtask

  initial begin
    total = 0; bad = 0;
    rst = 1'b1;
    b2.lookup_valid = 1'b0; b2.lookup_index = '0; b2.lookup_tag = '0;
    b2.wr_en = 1'b0; b2.wr_index = '0; b2.wr_way = '0; b2.wr_valid = 1'b0;
    b2.wr_dirty = 1'b0; b2.wr_tag = '0; b2.wr_data = '0; b2.inv_req = 1'b0;
    b4.lookup_valid = 1'b0; b4.lookup_index = '0; b4.lookup_tag = '0;
    b4.wr_en = 1'b0; b4.wr_index = '0; b4.wr_way = '0; b4.wr_valid = 1'b0;
    b4.wr_dirty = 1'b0; b4.wr_tag = '0; b4.wr_data = '0; b4.inv_req = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    test_reset();
    test_hit_and_lru();
    test_back_to_back();
    test_read_old();
    test_dirty();
    test_plru4();
    test_invalidate();
    test_reset_mid_walk();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
